npu_sram_dp_fill: RTL and testbench

//   Parametrised true-dual-port on-chip SRAM with two Avalon-MM slave ports (s1, s2) on one clock.

---
 rtl/npu_sram_dp_fill.sv | 223 ++++++++++++++++++++++
 tb/tb_npu_sram_dp_fill.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_sram_dp_fill.sv
// npu_sram_dp_fill
// True-dual-port byte-lane SRAM with two Avalon-MM slave ports on one clock,
// a 1- or 2-cycle read pipeline, lane-merged same-address write handling and
// a hardware fill engine that writes one constant to every word.
//
// Fill FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ports serve traffic; fill_start latches fill_value
//   ST_FILL | one word per cycle from address 0 upward, both ports stalled
//   ST_DONE | single cycle, fill_done pulses, ports accept traffic again
module npu_sram_dp_fill #(
  parameter int  DATA_W   = 16,
  parameter int  DEPTH    = 4096,
  parameter int  READ_LAT = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,

  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest,

  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              collision
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter is one bit wider than the address so the last word never wraps.
  localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              collision_q;

  logic              stall;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;

  // Index 0 is port s1, index 1 is port s2.
  logic [1:0]                   wr_acc;
  logic [1:0]                   rd_acc;
  logic [1:0][ADDR_W-1:0]       p_addr;
  logic [1:0][BE_W-1:0]         p_be;
  logic [1:0][DATA_W-1:0]       p_wdata;

  logic [DATA_W-1:0]            ram_rd1;
  logic [DATA_W-1:0]            ram_rd2;

  logic [1:0]                   rv1_q;
  logic [1:0][DATA_W-1:0]       rd1_q;
  logic [1:0]                   rd_valid;
  logic [1:0][DATA_W-1:0]       rd_data;

  assign stall     = (state_q == ST_FILL);
  assign fill_we   = (state_q == ST_FILL);
  assign fill_addr = fill_cnt_q[ADDR_W-1:0];

  assign p_addr  = {s2_address, s1_address};
  assign p_be    = {s2_byteenable, s1_byteenable};
  assign p_wdata = {s2_writedata, s1_writedata};

  // A request carrying both read and write is a write only.
  assign wr_acc[0] = s1_chipselect & s1_write & ~stall;
  assign wr_acc[1] = s2_chipselect & s2_write & ~stall;
  assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~stall;
  assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~stall;

  // Fill sequencing: latch value, sweep every address once, pulse done.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    fill_val_d = fill_val_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
          fill_val_d = fill_value;
        end
      end
      ST_FILL: begin
        fill_cnt_d = fill_cnt_q + CNT_ONE;
        if (fill_cnt_q == FILL_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fill FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      fill_val_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      fill_val_q <= fill_val_d;
    end
  end

  // Flag a same-address dual write one cycle after it lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= wr_acc[0] & wr_acc[1] & (s1_address == s2_address);
    end
  end

  // Storage is split into byte lanes so each lane resolves its own writer.
  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    // Port s1 is written after s2, so s1 owns any lane both ports enable.
    always_ff @(posedge clk) begin
      if (fill_we) begin
        lane_mem[fill_addr] <= fill_val_q[8*l +: 8];
      end else begin
        if (wr_acc[1] && p_be[1][l]) begin
          lane_mem[p_addr[1]] <= p_wdata[1][8*l +: 8];
        end
        if (wr_acc[0] && p_be[0][l]) begin
          lane_mem[p_addr[0]] <= p_wdata[0][8*l +: 8];
        end
      end
    end

    assign ram_rd1[8*l +: 8] = lane_mem[p_addr[0]];
    assign ram_rd2[8*l +: 8] = lane_mem[p_addr[1]];
  end

  // First read stage: sample the pre-write word at the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv1_q    <= '0;
      rd1_q[0] <= '0;
      rd1_q[1] <= '0;
    end else begin
      rv1_q <= rd_acc;
      if (rd_acc[0]) begin
        rd1_q[0] <= ram_rd1;
      end
      if (rd_acc[1]) begin
        rd1_q[1] <= ram_rd2;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [1:0]             rv2_q;
    logic [1:0][DATA_W-1:0] rd2_q;

    // Output register: data only moves on a valid, so it holds in between.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rv2_q    <= '0;
        rd2_q[0] <= '0;
        rd2_q[1] <= '0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q[0]) begin
          rd2_q[0] <= rd1_q[0];
        end
        if (rv1_q[1]) begin
          rd2_q[1] <= rd1_q[1];
        end
      end
    end

    assign rd_valid = rv2_q;
    assign rd_data  = rd2_q;
  end else begin : g_lat1
    assign rd_valid = rv1_q;
    assign rd_data  = rd1_q;
  end

  assign s1_readdata      = rd_data[0];
  assign s1_readdatavalid = rd_valid[0];
  assign s1_waitrequest   = stall;
  assign s2_readdata      = rd_data[1];
  assign s2_readdatavalid = rd_valid[1];
  assign s2_waitrequest   = stall;

  assign fill_busy = (state_q == ST_FILL);
  assign fill_done = (state_q == ST_DONE);
  assign collision = collision_q;

endmodule

// File: tb/tb_npu_sram_dp_fill.sv
// Testbench for npu_sram_dp_fill (DEPTH=16, READ_LAT=2).
module tb_npu_sram_dp_fill;

  localparam int DW  = 16;
  localparam int DEP = 16;
  localparam int RL  = 2;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]          cs, rd, wr;
  logic [1:0][3:0]     ad;
  logic [1:0][1:0]     be;
  logic [1:0][DW-1:0]  wd;
  logic                fill_start;
  logic [DW-1:0]       fill_value;

  logic [DW-1:0] s1_readdata, s2_readdata;
  logic s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
  logic fill_busy, fill_done, collision;

  always #5 clk = ~clk;

  npu_sram_dp_fill #(.DATA_W(DW), .DEPTH(DEP), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .s1_address(ad[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(ad[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .collision(collision)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word array with per-byte known flags, a queue of
  // expected read returns per port, and a fill described by its next address.
  typedef struct { int due; logic [DW-1:0] data; logic [DW-1:0] mask; } rd_t;
  logic [DW-1:0] mmem   [DEP];
  logic [1:0]    mknown [DEP];
  rd_t rq1[$];
  rd_t rq2[$];
  logic [DW-1:0] held   [2];
  logic [DW-1:0] hmask  [2];
  bit  m_busy, m_done, m_coll;
  int  m_faddr;
  logic [DW-1:0] m_fval;
  int  edge_n = 0;

  typedef struct {
    int wport; logic [3:0] addr; logic [1:0] be; logic [DW-1:0] pre; logic [DW-1:0] data; logic [DW-1:0] expv;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp, logic [31:0] mask = 32'hFFFF_FFFF);
    n_tests++;
    if (((act ^ exp) & mask) != 0) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] bmask(logic [1:0] k);
    return {{8{k[1]}}, {8{k[0]}}};
  endfunction

  function automatic logic cur_v(int p);
    return (p == 0) ? s1_readdatavalid : s2_readdatavalid;
  endfunction

  function automatic logic [DW-1:0] cur_d(int p);
    return (p == 0) ? s1_readdata : s2_readdata;
  endfunction

  task automatic idle();
    cs = '0; rd = '0; wr = '0; ad = '0; be = '0; wd = '0;
  endtask

  // One clock: apply the model's view of the coming edge, then compare.
  task automatic step();
    bit wt;
    bit [1:0] wacc, racc;
    rd_t e;
    bit ev;
    wt = m_busy;
    edge_n++;
    for (int p = 0; p < 2; p++) begin
      wacc[p] = cs[p] & wr[p] & !wt;
      racc[p] = cs[p] & rd[p] & !wr[p] & !wt;
      if (racc[p]) begin
        e.due = edge_n + RL - 1;
        e.data = mmem[ad[p]];
        e.mask = bmask(mknown[ad[p]]);
        if (p == 0) rq1.push_back(e); else rq2.push_back(e);
      end
    end
    for (int l = 0; l < 2; l++) begin
      for (int p = 1; p >= 0; p--) begin
        if (wacc[p] && be[p][l]) begin
          mmem[ad[p]][8*l +: 8] = wd[p][8*l +: 8];
          mknown[ad[p]][l] = 1'b1;
        end
      end
    end
    m_coll = wacc[0] & wacc[1] & (ad[0] == ad[1]);
    if (m_busy) begin
      mmem[m_faddr] = m_fval;
      mknown[m_faddr] = 2'b11;
      m_faddr++;
      if (m_faddr == DEP) begin m_busy = 0; m_done = 1; end
    end else if (m_done) begin
      m_done = 0;
    end else if (fill_start) begin
      m_busy = 1; m_faddr = 0; m_fval = fill_value;
    end
    @(posedge clk); #1;
    chk("s1_waitrequest", s1_waitrequest, m_busy);
    chk("s2_waitrequest", s2_waitrequest, m_busy);
    chk("fill_busy", fill_busy, m_busy);
    chk("fill_done", fill_done, m_done);
    chk("collision", collision, m_coll);
    for (int p = 0; p < 2; p++) begin
      ev = 0;
      if (p == 0 && rq1.size() > 0 && rq1[0].due == edge_n) begin e = rq1.pop_front(); ev = 1; end
      if (p == 1 && rq2.size() > 0 && rq2[0].due == edge_n) begin e = rq2.pop_front(); ev = 1; end
      if (ev) begin held[p] = e.data; hmask[p] = e.mask; end
      chk($sformatf("s%0d_readdatavalid", p+1), cur_v(p), ev);
      chk($sformatf("s%0d_readdata", p+1), cur_d(p), held[p], hmask[p]);
    end
  endtask

  task automatic write_op(int p, logic [3:0] a, logic [1:0] b, logic [DW-1:0] d);
    idle();
    cs[p] = 1'b1; wr[p] = 1'b1; ad[p] = a; be[p] = b; wd[p] = d;
    step();
    idle();
  endtask

  task automatic read_cap(int p, logic [3:0] a, output logic [DW-1:0] d);
    int n;
    idle();
    cs[p] = 1'b1; rd[p] = 1'b1; ad[p] = a;
    step();
    idle();
    n = 0;
    while (!cur_v(p) && n < 8) begin step(); n++; end
    chk("read_returned", cur_v(p), 1'b1);
    d = cur_d(p);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    fill_start = 1'b0;
    #1;
    chk("rst_s1_wait", s1_waitrequest, 0);
    chk("rst_s2_wait", s2_waitrequest, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_coll", collision, 0);
    chk("rst_s1_rv", s1_readdatavalid, 0);
    chk("rst_s2_rv", s2_readdatavalid, 0);
    chk("rst_s1_rd", s1_readdata, 0);
    chk("rst_s2_rd", s2_readdata, 0);
    if (m_busy) for (int i = m_faddr; i < DEP; i++) mknown[i] = 2'b00;
    rq1.delete(); rq2.delete();
    for (int p = 0; p < 2; p++) begin held[p] = '0; hmask[p] = '1; end
    m_busy = 0; m_done = 0; m_coll = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Start a fill, stall-test both ports while busy, optionally stop at word abort_at.
  task automatic fill_run(logic [DW-1:0] v, int abort_at, output int busy_cnt, output int done_cnt);
    idle();
    fill_start = 1'b1; fill_value = v;
    step();
    fill_start = 1'b0;
    busy_cnt = fill_busy ? 1 : 0;
    done_cnt = 0;
    for (int n = 0; n < DEP + 6; n++) begin
      if (abort_at >= 0 && m_busy && m_faddr == abort_at) break;
      if (done_cnt > 0 && !fill_done) break;
      idle();
      fill_start = m_busy ? 1'($urandom_range(0, 1)) : m_done;
      fill_value = DW'($urandom);
      if (m_busy) begin
        for (int p = 0; p < 2; p++) begin
          cs[p] = 1'b1; rd[p] = 1'($urandom); wr[p] = 1'($urandom);
          ad[p] = 4'($urandom); be[p] = 2'($urandom); wd[p] = DW'($urandom);
        end
      end
      step();
      if (fill_busy) busy_cnt++;
      if (fill_done) done_cnt++;
    end
    idle();
    fill_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int bc, dc;
    logic          v_rec [13];
    logic [DW-1:0] d_rec [13];
    bit            ev;

    vecs[0] = '{0, 4'd5,  2'b11, 16'hFFFF, 16'h1234, 16'h1234};
    vecs[1] = '{0, 4'd7,  2'b01, 16'hFFFF, 16'h00AB, 16'hFFAB};
    vecs[2] = '{1, 4'd3,  2'b10, 16'h5A5A, 16'hC3FF, 16'hC35A};
    vecs[3] = '{0, 4'd12, 2'b00, 16'h1357, 16'hFFFF, 16'h1357};
    vecs[4] = '{1, 4'd0,  2'b11, 16'h8001, 16'h7FFE, 16'h7FFE};
    vecs[5] = '{0, 4'd15, 2'b10, 16'h0F0F, 16'hAAAA, 16'hAA0F};

    for (int i = 0; i < DEP; i++) begin mmem[i] = '0; mknown[i] = 2'b00; end
    for (int p = 0; p < 2; p++) begin held[p] = '0; hmask[p] = '1; end
    m_busy = 0; m_done = 0; m_coll = 0; m_faddr = 0; m_fval = '0;

    reset = 1'b1; idle(); fill_start = 1'b0; fill_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", fill_busy, 0);
    chk("init_done", fill_done, 0);
    chk("init_wait", s1_waitrequest | s2_waitrequest, 0);
    chk("init_rv", s1_readdatavalid | s2_readdatavalid, 0);
    chk("init_rd", {s1_readdata, s2_readdata}, 0);
    chk("init_coll", collision, 0);
    reset = 1'b0;

    // Cross-port write/read with byte enables.
    for (int i = 0; i < 6; i++) begin
      write_op(vecs[i].wport, vecs[i].addr, 2'b11, vecs[i].pre);
      write_op(vecs[i].wport, vecs[i].addr, vecs[i].be, vecs[i].data);
      read_cap(1 - vecs[i].wport, vecs[i].addr, d);
      chk($sformatf("vec%0d_readback", i), d, vecs[i].expv);
    end

    // Same-address dual write.
    idle();
    cs = 2'b11; wr = 2'b11; ad[0] = 4'd9; ad[1] = 4'd9;
    be[0] = 2'b01; wd[0] = 16'h1111; be[1] = 2'b11; wd[1] = 16'h2222;
    step();
    chk("coll_pulse", collision, 1);
    idle();
    step();
    chk("coll_clear", collision, 0);
    read_cap(0, 4'd9, d);
    chk("coll_merge", d, 16'h2211);

    // Full fill.
    fill_run(16'hA5A5, -1, bc, dc);
    chk("fill_busy_cycles", bc, DEP);
    chk("fill_done_pulses", dc, 1);
    for (int a = 0; a < DEP; a++) begin
      read_cap(a % 2, 4'(a), d);
      chk($sformatf("fill_word%0d", a), d, 16'hA5A5);
    end

    // Reset at fill word 6, then restart from address 0.
    fill_run(16'h3C3C, 6, bc, dc);
    chk("abort_no_done", dc, 0);
    do_reset();
    fill_run(16'h5AA5, -1, bc, dc);
    chk("refill_busy_cycles", bc, DEP);
    chk("refill_done_pulses", dc, 1);
    for (int a = 0; a < 6; a++) begin
      read_cap(1, 4'(a), d);
      chk($sformatf("refill_word%0d", a), d, 16'h5AA5);
    end

    // Ten back-to-back reads on s1.
    for (int i = 0; i < 10; i++) write_op(1, 4'(i), 2'b11, 16'h1000 + 16'(i) * 16'h0101);
    for (int k = 0; k < 13; k++) begin
      idle();
      if (k < 10) begin cs[0] = 1'b1; rd[0] = 1'b1; ad[0] = 4'(k); end
      step();
      v_rec[k] = s1_readdatavalid;
      d_rec[k] = s1_readdata;
    end
    for (int k = 0; k < 13; k++) begin
      ev = (k >= RL - 1) && (k < RL - 1 + 10);
      chk($sformatf("b2b_valid%0d", k), v_rec[k], ev);
      if (ev) chk($sformatf("b2b_data%0d", k), d_rec[k], 16'h1000 + 16'(k - RL + 1) * 16'h0101);
    end

    // Random traffic on both ports with occasional fills.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        cs[p] = ($urandom_range(0, 3) != 0);
        rd[p] = 1'($urandom); wr[p] = 1'($urandom);
        ad[p] = 4'($urandom_range(0, DEP - 1));
        be[p] = 2'($urandom); wd[p] = DW'($urandom);
      end
      fill_start = ($urandom_range(0, 49) == 0);
      fill_value = DW'($urandom);
      step();
    end
    idle();
    fill_start = 1'b0;
    repeat (DEP + 4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
